// File: rtl/para_sram_reader_if.sv
// Bus bundle between para_sram_reader, the paraSRAM read port and the downstream consumer.
// Defining PARA_SRAM_READER_PERF_EN adds the o_stall_cnt performance output.
interface para_sram_reader_if #(
    parameter int NUM_PARALLEL = 6,
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 24
);
    logic                                 i_start;
    logic [ADDR_W-1:0]                    i_base_addr;
    logic [ADDR_W-1:0]                    i_length;
    logic [NUM_PARALLEL-1:0][ADDR_W-1:0]  o_read_address;
    logic [NUM_PARALLEL-1:0][DATA_W-1:0]  i_read_data;
    logic [NUM_PARALLEL-1:0][DATA_W-1:0]  o_data;
    logic                                 o_valid;
    logic                                 i_ready;
    logic                                 o_busy;
    logic                                 o_done;
`ifdef PARA_SRAM_READER_PERF_EN
    logic [15:0]                          o_stall_cnt;
`endif

    modport slave (
        input  i_start, i_base_addr, i_length, i_read_data, i_ready,
        output o_read_address, o_data, o_valid, o_busy, o_done
`ifdef PARA_SRAM_READER_PERF_EN
        , output o_stall_cnt
`endif
    );

    modport master (
        output i_start, i_base_addr, i_length, i_read_data, i_ready,
        input  o_read_address, o_data, o_valid, o_busy, o_done
`ifdef PARA_SRAM_READER_PERF_EN
        , input o_stall_cnt
`endif
    );
endinterface

// File: rtl/para_sram_reader.sv
// Streaming read initiator for paraSRAM: walks an address range, absorbs read latency, emits beats on valid/ready.
// Optional feature macro: PARA_SRAM_READER_PERF_EN (adds the saturating o_stall_cnt counter).
//
// state | meaning
// IDLE  | waiting for i_start; FIFO and in-flight pipe are empty
// RUN   | issuing beats whenever FIFO + in-flight occupancy leaves room
// DRAIN | all beats issued; waiting for the last beat handshake
module para_sram_reader #(
    parameter int NUM_PARALLEL = 6,
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 24,
    parameter int READ_LAT     = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    para_sram_reader_if.slave bus
);
    localparam int D    = READ_LAT + 2;
    localparam int NSTG = READ_LAT + 1;
    localparam int PW   = $clog2(D);
    localparam int CW   = $clog2(D + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef logic [NUM_PARALLEL-1:0][DATA_W-1:0] beat_t;
    typedef logic [NUM_PARALLEL-1:0][ADDR_W-1:0] lanes_t;

    state_t            state_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issue_cnt_q;
    logic [ADDR_W-1:0] dlvr_cnt_q;
    logic [ADDR_W-1:0] next_addr_q;
    lanes_t            rd_addr_q;
    logic [NSTG-1:0]   inflight_q;
    beat_t             fifo_q [D];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     fifo_cnt_q;
    logic              done_q;

    logic              start_acc;
    logic              issue;
    logic              capture;
    logic              pop;
    logic              valid;
    logic [ADDR_W-1:0] issue_base;
    int                occupancy;

    assign valid      = (fifo_cnt_q != '0);
    assign pop        = valid && bus.i_ready;
    assign capture    = inflight_q[READ_LAT];
    assign start_acc  = (state_q == IDLE) && bus.i_start;
    assign issue_base = (state_q == IDLE) ? bus.i_base_addr : next_addr_q;

    // A pop on this edge frees a slot, which keeps a full-rate stream at 1 beat/cycle without overflow.
    always_comb begin
        occupancy = int'(fifo_cnt_q) - (pop ? 1 : 0);
        for (int s = 0; s < NSTG; s++) begin
            occupancy = occupancy + int'(inflight_q[s]);
        end
    end

    // Beat 0 goes out on the start edge itself; the FIFO is always empty in IDLE.
    assign issue = (start_acc && (bus.i_length != '0)) || ((state_q == RUN) && (occupancy < D));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            dlvr_cnt_q  <= '0;
            next_addr_q <= '0;
            rd_addr_q   <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < D; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            done_q     <= 1'b0;
            inflight_q <= {inflight_q[NSTG-2:0], issue};
            if (issue) begin
                for (int j = 0; j < NUM_PARALLEL; j++) begin
                    rd_addr_q[j] <= issue_base + ADDR_W'(j);
                end
                next_addr_q <= issue_base + ADDR_W'(NUM_PARALLEL);
            end
            if (capture) begin
                fifo_q[wr_ptr_q] <= bus.i_read_data;
                wr_ptr_q         <= (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q   <= (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + PW'(1);
                dlvr_cnt_q <= dlvr_cnt_q + ADDR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + CW'(capture) - CW'(pop);

            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        len_q      <= bus.i_length;
                        dlvr_cnt_q <= '0;
                        if (bus.i_length == '0) begin
                            issue_cnt_q <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            issue_cnt_q <= ADDR_W'(1);
                            state_q     <= (bus.i_length == ADDR_W'(1)) ? DRAIN : RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issue_cnt_q <= issue_cnt_q + ADDR_W'(1);
                        if (issue_cnt_q + ADDR_W'(1) == len_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (dlvr_cnt_q + ADDR_W'(1) == len_q)) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_read_address = rd_addr_q;
    assign bus.o_data         = fifo_q[rd_ptr_q];
    assign bus.o_valid        = valid;
    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_done         = done_q;

`ifdef PARA_SRAM_READER_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if (valid && !bus.i_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_para_sram_reader.sv
// Self-checking bench for para_sram_reader: directed transfers checked against a beat-queue model.
module tb_para_sram_reader;
    localparam int NP = 6;
    localparam int AW = 13;
    localparam int DW = 24;
    localparam int L  = 1;
    localparam int D  = L + 2;

    typedef logic [NP-1:0][DW-1:0] beat_t;
    typedef logic [NP-1:0][AW-1:0] lanes_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic          ready;
    beat_t         sram_pipe [L];

    int checks = 0;
    int errors = 0;

    para_sram_reader_if #(.NUM_PARALLEL(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    para_sram_reader #(.NUM_PARALLEL(NP), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(L)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.i_start     = start;
    assign bus.i_base_addr = base;
    assign bus.i_length    = len;
    assign bus.i_ready     = ready;
    assign bus.i_read_data = sram_pipe[L-1];

    // SRAM content: word at address n holds n+100, returned L edges after the address
    always @(posedge clk) begin
        for (int j = 0; j < NP; j++) begin
            sram_pipe[0][j] <= DW'(bus.o_read_address[j]) + DW'(100);
        end
        for (int i = 1; i < L; i++) begin
            sram_pipe[i] <= sram_pipe[i-1];
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t exp_beat(input int b, input int k);
        beat_t r;
        for (int j = 0; j < NP; j++) begin
            r[j] = DW'(((b + k * NP + j) % (1 << AW)) + 100);
        end
        return r;
    endfunction

    // Model state, updated at the negedge to describe the cycle after the next posedge
    beat_t  exp_q [$];
    logic   m_busy = 1'b0;
    logic   m_done = 1'b0;
    logic   b0 = 1'b0;
    int     m_base = 0;
    int     m_len = 0;
    int     issued = 0;
    int     accepted = 0;
    lanes_t prev_addr;

    always @(negedge clk) begin
        logic was_busy;
        if (rst) begin
            exp_q.delete();
            m_busy    = 1'b0;
            m_done    = 1'b0;
            b0        = 1'b0;
            issued    = 0;
            accepted  = 0;
            prev_addr = bus.o_read_address;
        end else begin
            chk("busy", bus.o_busy, m_busy);
            chk("done", bus.o_done, m_done);
            if (!m_busy) chk("idle_valid", bus.o_valid, 1'b0);
            if (bus.o_valid) begin
                if (exp_q.size() == 0) chk("extra_beat", bus.o_data, 0);
                else chk("beat_data", bus.o_data, exp_q[0]);
            end
            if (b0 || (m_busy && bus.o_read_address != prev_addr)) begin
                issued = b0 ? 1 : issued + 1;
                b0 = 1'b0;
                chk("issue_count", (issued <= m_len), 1'b1);
                for (int j = 0; j < NP; j++) begin
                    chk("issue_addr", bus.o_read_address[j], (m_base + (issued - 1) * NP + j) % (1 << AW));
                end
            end
            if (m_busy) chk("outstanding", (issued - accepted <= D), 1'b1);
            prev_addr = bus.o_read_address;

            was_busy = m_busy;
            m_done   = 1'b0;
            if (bus.o_valid && ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                accepted++;
                if (accepted == m_len) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (start && !was_busy) begin
                m_base   = int'(base);
                m_len    = int'(len);
                issued   = 0;
                accepted = 0;
                for (int k = 0; k < m_len; k++) exp_q.push_back(exp_beat(m_base, k));
                if (m_len == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    b0     = 1'b1;
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.o_done && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", bus.o_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wexp [NP];
        int n;
        wexp = '{8190, 8191, 0, 1, 2, 3};
        rst = 1'b1; start = 1'b0; base = '0; len = '0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_done", bus.o_done, 1'b0);
        chk("rst_addr", bus.o_read_address, 0);
        chk("rst_data", bus.o_data, 0);
        rst = 1'b0;
        tick();

        // Basic read, base 41, three beats
        base = 13'd41; len = 13'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < NP; j++) chk("basic_addr", bus.o_read_address[j], 41 + j);
        tick();
        chk("basic_lat_valid", bus.o_valid, 1'b0);
        tick();
        chk("basic_valid", bus.o_valid, 1'b1);
        chk("basic_d0_l0", bus.o_data[0], 141);
        chk("basic_d0_l5", bus.o_data[5], 146);
        tick();
        chk("basic_d1_l0", bus.o_data[0], 147);
        tick();
        chk("basic_d2_l5", bus.o_data[5], 158);
        tick();
        chk("basic_done", bus.o_done, 1'b1);
        chk("basic_busy", bus.o_busy, 1'b0);

        // Back-to-back start in the done cycle
        base = 13'd1000; len = 13'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", bus.o_busy, 1'b1);
        chk("b2b_addr", bus.o_read_address[0], 1000);
        wait_done(100);
        tick();

        // Backpressure: long initial stall, then ready 1,0,0 repeating
        ready = 1'b0; base = 13'd41; len = 13'd8; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("bp_issue_stop", bus.o_read_address[0], 53);
        chk("bp_valid", bus.o_valid, 1'b1);
        chk("bp_hold", bus.o_data[0], 141);
        n = 0;
        while (!bus.o_done && n < 300) begin
            ready = (n % 3 == 0);
            tick();
            n++;
        end
        chk("bp_done_seen", bus.o_done, 1'b1);
        chk("bp_all_beats", exp_q.size(), 0);
        ready = 1'b1;
        tick();

        // Address wrap
        base = 13'd8190; len = 13'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < NP; j++) chk("wrap_addr", bus.o_read_address[j], wexp[j]);
        wait_done(50);
        tick();

        // Zero length
        base = 13'd5; len = 13'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done", bus.o_done, 1'b1);
        chk("zero_busy", bus.o_busy, 1'b0);
        tick();
        chk("zero_done_once", bus.o_done, 1'b0);
        repeat (3) tick();

        // Reset two cycles into a ten-beat transfer
        base = 13'd200; len = 13'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.o_valid, 1'b0);
        chk("mid_rst_busy", bus.o_busy, 1'b0);
        chk("mid_rst_addr", bus.o_read_address, 0);
        chk("mid_rst_data", bus.o_data, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        base = 13'd0; len = 13'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(50);
        tick();

`ifdef PARA_SRAM_READER_PERF_EN
        ready = 1'b0; base = 13'd300; len = 13'd4; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!bus.o_valid && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        ready = 1'b1;
        wait_done(50);
        chk("perf_stall_cnt", bus.o_stall_cnt, 5);
        tick();
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
